// File: rtl/ariane_pkg.sv
// Core-wide types shared by the frontend and decode, including the fetch entry
// passed between them and the depth of the fetch entry buffer.
package ariane_pkg;

  localparam int unsigned FETCH_BUF_DEPTH = 4;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    cf_t         cf;
    logic [63:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]        address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf_ptr_ctrl.sv
// Read/write pointers and occupancy count for the fetch entry buffer.
// Flush overrides push and pop and returns everything to the empty state.
module fetch_buf_ptr_ctrl #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_rd_ptr_next, w_wr_ptr_next;
  logic [CNT_W-1:0] w_count_next;

  // DEPTH is a power of two, so pointer wrap is the natural overflow
  always_comb begin
    w_rd_ptr_next = r_rd_ptr;
    w_wr_ptr_next = r_wr_ptr;
    w_count_next  = r_count;
    if (flush_i) begin
      w_rd_ptr_next = '0;
      w_wr_ptr_next = '0;
      w_count_next  = '0;
    end else begin
      if (push_i) w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
      if (pop_i)  w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
      w_count_next = r_count + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_count  <= w_count_next;
    end
  end

  assign rd_ptr_o = r_rd_ptr;
  assign wr_ptr_o = r_wr_ptr;
  assign count_o  = r_count;
  assign full_o   = (r_count == CNT_W'(DEPTH));
  assign empty_o  = (r_count == '0);

endmodule

// File: rtl/fetch_entry_buffer.sv
// Elastic FIFO between frontend and decode. Handshake outputs come only from
// registered state, so there is no bypass and no ready_i -> ready_o path.
module fetch_entry_buffer
  import ariane_pkg::*;
#(
  parameter  int unsigned DEPTH = ariane_pkg::FETCH_BUF_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  fetch_entry_t     fetch_entry_i,
  input  logic             fetch_entry_valid_i,
  output logic             fetch_entry_ready_o,
  output fetch_entry_t     fetch_entry_o,
  output logic             fetch_entry_valid_o,
  input  logic             fetch_entry_ready_i,
  output logic [CNT_W-1:0] usage_o
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] w_rd_ptr, w_wr_ptr;
  logic [CNT_W-1:0] w_count;
  logic             w_full, w_empty, w_push, w_pop;

  assign fetch_entry_ready_o = ~w_full;
  assign fetch_entry_valid_o = ~w_empty;
  assign w_push = fetch_entry_valid_i & fetch_entry_ready_o;
  assign w_pop  = fetch_entry_valid_o & fetch_entry_ready_i;

  fetch_buf_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .push_i   (w_push),
    .pop_i    (w_pop),
    .rd_ptr_o (w_rd_ptr),
    .wr_ptr_o (w_wr_ptr),
    .count_o  (w_count),
    .full_o   (w_full),
    .empty_o  (w_empty)
  );

  // A push during flush still lands in storage; the pointer reset discards it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[w_wr_ptr] <= fetch_entry_i;
    end
  end

  assign fetch_entry_o = r_mem[w_rd_ptr];
  assign usage_o       = w_count;

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    w_count <= CNT_W'(DEPTH))
    else $error("fetch_entry_buffer: occupancy above DEPTH");

  a_input_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (fetch_entry_valid_i && !fetch_entry_ready_o) |=>
      (!fetch_entry_valid_i || $stable(fetch_entry_i)))
    else $warning("fetch_entry_buffer: fetch_entry_i changed while held off");

endmodule

// File: tb/tb_fetch_entry_buffer.sv
// Directed bench for fetch_entry_buffer: fill, drain, streaming, flush,
// exception pass-through and asynchronous reset.
module tb_fetch_entry_buffer;
  import ariane_pkg::*;

  localparam int unsigned CNT_W = $clog2(FETCH_BUF_DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  fetch_entry_t     fetch_entry_i = '0;
  logic             fetch_entry_valid_i = 1'b0;
  logic             fetch_entry_ready_o;
  fetch_entry_t     fetch_entry_o;
  logic             fetch_entry_valid_o;
  logic             fetch_entry_ready_i = 1'b0;
  logic [CNT_W-1:0] usage_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  fetch_entry_buffer #(.DEPTH(FETCH_BUF_DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .fetch_entry_i       (fetch_entry_i),
    .fetch_entry_valid_i (fetch_entry_valid_i),
    .fetch_entry_ready_o (fetch_entry_ready_o),
    .fetch_entry_o       (fetch_entry_o),
    .fetch_entry_valid_o (fetch_entry_valid_o),
    .fetch_entry_ready_i (fetch_entry_ready_i),
    .usage_o             (usage_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_e(input string tag, input fetch_entry_t obs, input fetch_entry_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [63:0] addr);
    fetch_entry_t e;
    e = '0;
    e.address     = addr;
    e.instruction = 32'h0000_0013 ^ addr[31:0];
    return e;
  endfunction

  initial begin
    int          exp_usage [4];
    logic [63:0] exp_head;
    fetch_entry_t ex_entry;
    exp_usage = '{3, 3, 2, 1};

    // 1. reset held for 3 cycles
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_valid", 64'(fetch_entry_valid_o), 64'd0);
    chk("rst_ready", 64'(fetch_entry_ready_o), 64'd1);
    chk("rst_usage", 64'(usage_o), 64'd0);
    chk_e("rst_entry", fetch_entry_o, '0);

    // 2. fill with decode stalled
    fetch_entry_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fetch_entry_valid_i = 1'b1;
      fetch_entry_i = mk(64'h8000_0000 + 64'(4 * k));
      tick();
      chk($sformatf("fill_usage%0d", k), 64'(usage_o), 64'(k + 1));
    end
    chk("full_ready", 64'(fetch_entry_ready_o), 64'd0);
    fetch_entry_i = mk(64'h8000_0010);
    tick();
    chk("full_usage_held", 64'(usage_o), 64'd4);
    chk("full_head", fetch_entry_o.address, 64'h8000_0000);

    // 3. drain four entries; 0x80000010 accepted one cycle after first pop
    fetch_entry_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_head%0d", k), fetch_entry_o.address, 64'h8000_0000 + 64'(4 * k));
      tick();
      if (k == 0) chk("drain_ready", 64'(fetch_entry_ready_o), 64'd1);
      if (k == 1) fetch_entry_valid_i = 1'b0;
      chk($sformatf("drain_usage%0d", k), 64'(usage_o), 64'(exp_usage[k]));
    end
    fetch_entry_ready_i = 1'b0;
    chk("drain_late_entry", fetch_entry_o.address, 64'h8000_0010);

    // 4. steady streaming at usage 2 across pointer wrap
    fetch_entry_valid_i = 1'b1;
    fetch_entry_i = mk(64'hA000_0000);
    tick();
    chk("stream_prefill", 64'(usage_o), 64'd2);
    fetch_entry_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fetch_entry_i = mk(64'hA000_0004 + 64'(4 * i));
      exp_head = (i == 0) ? 64'h8000_0010 : 64'hA000_0000 + 64'(4 * (i - 1));
      chk_e($sformatf("stream_head%0d", i), fetch_entry_o, mk(exp_head));
      tick();
      chk($sformatf("stream_usage%0d", i), 64'(usage_o), 64'd2);
    end

    // 5. flush with simultaneous push and pop at usage 3
    fetch_entry_ready_i = 1'b0;
    fetch_entry_i = mk(64'hA000_0024);
    tick();
    chk("preflush_usage", 64'(usage_o), 64'd3);
    chk("preflush_head", fetch_entry_o.address, 64'hA000_001C);
    flush_i = 1'b1;
    fetch_entry_ready_i = 1'b1;
    fetch_entry_i = mk(64'h9000_0000);
    tick();
    flush_i = 1'b0;
    fetch_entry_valid_i = 1'b0;
    fetch_entry_ready_i = 1'b0;
    chk("flush_usage", 64'(usage_o), 64'd0);
    chk("flush_valid", 64'(fetch_entry_valid_o), 64'd0);
    chk("flush_ready", 64'(fetch_entry_ready_o), 64'd1);
    tick();
    chk("flush_valid_stays", 64'(fetch_entry_valid_o), 64'd0);
    fetch_entry_valid_i = 1'b1;
    fetch_entry_i = mk(64'hB000_0000);
    tick();
    fetch_entry_valid_i = 1'b0;
    chk("postflush_head", fetch_entry_o.address, 64'hB000_0000);
    chk("postflush_usage", 64'(usage_o), 64'd1);
    fetch_entry_ready_i = 1'b1;
    tick();
    fetch_entry_ready_i = 1'b0;
    chk("postflush_empty", 64'(usage_o), 64'd0);

    // 6. exception entry passes through unmodified, no bypass
    ex_entry = '0;
    ex_entry.address = 64'h8000_1000;
    ex_entry.instruction = 32'hFFFF_FFFF;
    ex_entry.branch_predict.cf = Branch;
    ex_entry.branch_predict.predict_address = 64'h8000_2000;
    ex_entry.ex.valid = 1'b1;
    ex_entry.ex.cause = 64'd2;
    ex_entry.ex.tval = 64'h0000_0000_FFFF_FFFF;
    fetch_entry_i = ex_entry;
    fetch_entry_valid_i = 1'b1;
    chk("ex_no_bypass", 64'(fetch_entry_valid_o), 64'd0);
    tick();
    fetch_entry_valid_i = 1'b0;
    chk("ex_valid", 64'(fetch_entry_valid_o), 64'd1);
    chk_e("ex_entry", fetch_entry_o, ex_entry);
    chk("ex_usage", 64'(usage_o), 64'd1);

    // 7. asynchronous reset mid-operation clears state before any edge
    #3 rst_i = 1'b1;
    #1;
    chk("arst_usage", 64'(usage_o), 64'd0);
    chk("arst_valid", 64'(fetch_entry_valid_o), 64'd0);
    chk_e("arst_entry", fetch_entry_o, '0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("arst_ready", 64'(fetch_entry_ready_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
